// File: rtl/cbus_axi_bridge_if.sv
// Bundle of the cbus request/response pair and the five AXI3 channels between
// the cache arbiter, the bridge and the SoC interconnect.
interface cbus_axi_bridge_if #(
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
);
    typedef struct packed {
        logic                  valid;
        logic                  is_write;
        logic [2:0]            size;
        logic [31:0]           addr;
        logic [DATA_W/8-1:0]   strobe;
        logic [DATA_W-1:0]     data;
        logic [3:0]            len;
    } cbus_req_t;

    typedef struct packed {
        logic                  ready;
        logic                  last;
        logic [DATA_W-1:0]     data;
    } cbus_resp_t;

    cbus_req_t  creq;
    cbus_resp_t cresp;

    logic [ID_W-1:0]     arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic                bus_err;

    // The bridge is the AXI master and the cbus responder.
    modport master (
        input  creq,
        output cresp,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output bus_err
    );

    modport slave (
        output creq,
        input  cresp,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  bus_err
    );
endinterface

// File: rtl/cbus_axi_bridge.sv
// Single-outstanding cbus to AXI3 bridge: one arbitrated cache transaction is
// replayed as an AR/R or AW/W/B sequence, single-beat or INCR burst.
module cbus_axi_bridge #(
    parameter int AXI_ID = 0,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    cbus_axi_bridge_if.master  bus
);
    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    logic              resp_ready;
    logic              resp_last;
    logic [DATA_W-1:0] resp_data;
    logic              err;
    logic [1:0]        burst;
    logic              unused_ids;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        resp_ready = 1'b0;
        resp_last  = 1'b0;
        resp_data  = {DATA_W{1'b0}};
        err        = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q blanks the cycle right after a completion so a stale
                // creq.valid from the finished transaction is never re-sampled.
                if (bus.creq.valid && !done_q) begin
                    addr_d  = bus.creq.addr;
                    len_d   = bus.creq.len;
                    size_d  = bus.creq.size;
                    cnt_d   = '0;
                    state_d = bus.creq.is_write ? AW : AR;
                end
            end
            AR: begin
                if (bus.arready) begin
                    cnt_d   = '0;
                    state_d = R;
                end
            end
            R: begin
                resp_data = bus.rdata;
                if (bus.rvalid) begin
                    resp_ready = 1'b1;
                    resp_last  = bus.rlast;
                    cnt_d      = cnt_q + 4'd1;
                    // Flag a bad response or rlast disagreeing with the beat count.
                    err = (bus.rresp != RESP_OKAY) || (bus.rlast != (cnt_q == len_q));
                    if (bus.rlast) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            AW: begin
                if (bus.awready) begin
                    cnt_d   = '0;
                    state_d = W;
                end
            end
            W: begin
                if (bus.wready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_q) begin
                        state_d = B;
                    end else begin
                        resp_ready = 1'b1;
                    end
                end
            end
            B: begin
                if (bus.bvalid) begin
                    resp_ready = 1'b1;
                    resp_last  = 1'b1;
                    err        = (bus.bresp != RESP_OKAY);
                    state_d    = IDLE;
                    done_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign burst = (len_q != 4'd0) ? BURST_INCR : BURST_FIXED;

    assign bus.arid    = ID_W'(AXI_ID);
    assign bus.araddr  = addr_q;
    assign bus.arlen   = len_q;
    assign bus.arsize  = size_q;
    assign bus.arburst = burst;
    assign bus.arvalid = (state_q == AR);
    assign bus.rready  = (state_q == R);

    assign bus.awid    = ID_W'(AXI_ID);
    assign bus.awaddr  = addr_q;
    assign bus.awlen   = len_q;
    assign bus.awsize  = size_q;
    assign bus.awburst = burst;
    assign bus.awvalid = (state_q == AW);

    // Write data is streamed straight from the requester, which advances on cresp.ready.
    assign bus.wid     = ID_W'(AXI_ID);
    assign bus.wdata   = bus.creq.data;
    assign bus.wstrb   = bus.creq.strobe;
    assign bus.wlast   = (state_q == W) && (cnt_q == len_q);
    assign bus.wvalid  = (state_q == W);
    assign bus.bready  = (state_q == B);

    assign bus.cresp   = {resp_ready, resp_last, resp_data};
    assign bus.bus_err = err;

    assign unused_ids  = ^{bus.rid, bus.bid};
endmodule

// File: tb/tb_cbus_axi_bridge.sv
// Randomized scoreboard bench for cbus_axi_bridge: drivers queue the expected
// AXI requests, write beats and cbus responses; a negedge monitor checks them.
module tb_cbus_axi_bridge;
    logic clk;
    logic reset;

    cbus_axi_bridge_if #(.ID_W(4), .DATA_W(32)) bus ();

    cbus_axi_bridge #(.AXI_ID(0), .ID_W(4), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        bit          wr;
    } addr_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        bit          last;
    } wbeat_t;

    // kind: 0 read beat, 1 write per-beat pulse, 2 write completion
    typedef struct {
        bit          last;
        logic [31:0] data;
        bit          chk_data;
        bit          err;
        int          kind;
    } resp_t;

    addr_t  aq[$];
    wbeat_t wq[$];
    resp_t  rq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int txn   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.creq.valid    = 1'b0;
        bus.creq.is_write = 1'b0;
        bus.creq.size     = '0;
        bus.creq.addr     = '0;
        bus.creq.strobe   = '0;
        bus.creq.data     = '0;
        bus.creq.len      = '0;
        bus.arready = 1'b0;
        bus.rid     = '0;
        bus.rdata   = '0;
        bus.rresp   = '0;
        bus.rlast   = 1'b0;
        bus.rvalid  = 1'b0;
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bid     = '0;
        bus.bresp   = '0;
        bus.bvalid  = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    addr_t  m_a;
    wbeat_t m_w;
    resp_t  m_r;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.arvalid && bus.awvalid) chk("ar_aw_both_valid", bus.awvalid, 1'b0);
            if (bus.arvalid && bus.arready) begin
                if (aq.size() == 0) chk("ar_unexpected", bus.arvalid, 1'b0);
                else begin
                    m_a = aq.pop_front();
                    chk("ar_is_read", 32'(m_a.wr), 0);
                    chk("araddr", bus.araddr, m_a.addr);
                    chk("arlen", 32'(bus.arlen), 32'(m_a.len));
                    chk("arsize", 32'(bus.arsize), 32'(m_a.size));
                    chk("arburst", 32'(bus.arburst), 32'(m_a.burst));
                    chk("arid", 32'(bus.arid), 0);
                end
            end
            if (bus.awvalid && bus.awready) begin
                if (aq.size() == 0) chk("aw_unexpected", bus.awvalid, 1'b0);
                else begin
                    m_a = aq.pop_front();
                    chk("aw_is_write", 32'(m_a.wr), 1);
                    chk("awaddr", bus.awaddr, m_a.addr);
                    chk("awlen", 32'(bus.awlen), 32'(m_a.len));
                    chk("awsize", 32'(bus.awsize), 32'(m_a.size));
                    chk("awburst", 32'(bus.awburst), 32'(m_a.burst));
                end
            end
            if (bus.wvalid && bus.wready) begin
                if (wq.size() == 0) chk("w_unexpected", bus.wvalid, 1'b0);
                else begin
                    m_w = wq.pop_front();
                    chk("wdata", bus.wdata, m_w.data);
                    chk("wstrb", 32'(bus.wstrb), 32'(m_w.strb));
                    chk("wlast", 32'(bus.wlast), 32'(m_w.last));
                end
            end
            if (bus.cresp.ready) begin
                if (rq.size() == 0) chk("cresp_unexpected", bus.cresp.ready, 1'b0);
                else begin
                    m_r = rq.pop_front();
                    chk("cresp_last", 32'(bus.cresp.last), 32'(m_r.last));
                    if (m_r.chk_data) chk("cresp_data", bus.cresp.data, m_r.data);
                    chk("bus_err", 32'(bus.bus_err), 32'(m_r.err));
                    if (m_r.kind == 0) chk("cresp_with_rvalid", 32'(bus.rvalid), 1);
                    if (m_r.kind == 1) chk("cresp_with_wready", 32'(bus.wready), 1);
                    if (m_r.kind == 2) chk("cresp_with_bvalid", 32'(bus.bvalid), 1);
                end
            end else if (bus.bus_err) begin
                chk("bus_err_stray", 32'(bus.bus_err), 0);
            end
        end
    end

    // ---------------- read transaction ----------------
    // gap_mode: 0 rvalid every cycle, 1 alternate cycles, 2 random
    task automatic run_read(input logic [31:0] addr, input int len, input int size,
                            input int last_at, input int gap_mode, input int err_beat,
                            input logic [31:0] base, input bit seq);
        logic [31:0] d[16];
        addr_t a;
        resp_t r;
        int  cyc, beat;
        bit  ar_done, done, give;
        for (int i = 0; i < 16; i++) d[i] = seq ? base + 32'(i) : $urandom;
        a.addr = addr; a.len = 4'(len); a.size = 3'(size);
        a.burst = (len != 0) ? 2'b01 : 2'b00; a.wr = 1'b0;
        aq.push_back(a);
        for (int i = 0; i <= last_at; i++) begin
            r.last = (i == last_at); r.data = d[i]; r.chk_data = 1'b1; r.kind = 0;
            r.err  = (i == err_beat) || ((i == last_at) != (i == len));
            rq.push_back(r);
        end
        txn++;
        $display("txn %0d: READ addr=0x%08h len=%0d size=%0d rlast_at=%0d err_beat=%0d gaps=%0d",
                 txn, addr, len, size, last_at, err_beat, gap_mode);
        @(posedge clk); #1;
        bus.creq.valid = 1'b1; bus.creq.is_write = 1'b0; bus.creq.addr = addr;
        bus.creq.len = 4'(len); bus.creq.size = 3'(size);
        bus.arready = (gap_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        cyc = 0; beat = 0; ar_done = 0; done = 0; give = 0;
        while (!done && cyc < 300) begin
            @(negedge clk); cyc++;
            if (cyc == 2) chk("arvalid_latency", 32'(bus.arvalid), 1);
            if (bus.rvalid && bus.rready) begin
                if (beat == last_at) done = 1;
                beat++;
            end
            if (bus.arvalid && bus.arready) ar_done = 1;
            @(posedge clk); #1;
            bus.arready = ar_done ? 1'b0 : ((gap_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
            if (done) begin
                bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.creq.valid = 1'b0;
            end else if (ar_done) begin
                give = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? !give : 1'($urandom_range(0, 1));
                bus.rvalid = give; bus.rdata = d[beat]; bus.rlast = (beat == last_at);
                bus.rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
                bus.rid    = 4'($urandom);
            end
        end
        chk("read_done_in_budget", 32'(done), 1);
        @(negedge clk);
        chk("idle_after_read", {27'd0, bus.arvalid, bus.awvalid, bus.rready, bus.wvalid, bus.bready}, 0);
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // ---------------- write transaction ----------------
    task automatic run_write(input logic [31:0] addr, input int len, input int size,
                             input int stall, input int bdelay, input logic [1:0] bresp,
                             input int abort_beat);
        logic [31:0] d[16];
        logic [3:0]  s[16];
        addr_t a;
        wbeat_t w;
        resp_t r;
        int  cyc, idx, wbeat, wcnt, bcnt;
        bit  aw_done, w_done, done, aborted;
        for (int i = 0; i < 16; i++) begin
            d[i] = $urandom; s[i] = 4'($urandom);
        end
        a.addr = addr; a.len = 4'(len); a.size = 3'(size);
        a.burst = (len != 0) ? 2'b01 : 2'b00; a.wr = 1'b1;
        aq.push_back(a);
        for (int i = 0; i <= len; i++) begin
            w.data = d[i]; w.strb = s[i]; w.last = (i == len);
            wq.push_back(w);
        end
        for (int i = 0; i < len; i++) begin
            r.last = 1'b0; r.data = '0; r.chk_data = 1'b0; r.err = 1'b0; r.kind = 1;
            rq.push_back(r);
        end
        r.last = 1'b1; r.data = '0; r.chk_data = 1'b0; r.err = (bresp != 2'b00); r.kind = 2;
        rq.push_back(r);
        txn++;
        $display("txn %0d: WRITE addr=0x%08h len=%0d size=%0d stall=%0d bdelay=%0d bresp=%0d abort_beat=%0d",
                 txn, addr, len, size, stall, bdelay, bresp, abort_beat);
        @(posedge clk); #1;
        bus.creq.valid = 1'b1; bus.creq.is_write = 1'b1; bus.creq.addr = addr;
        bus.creq.len = 4'(len); bus.creq.size = 3'(size);
        bus.creq.data = d[0]; bus.creq.strobe = s[0];
        bus.awready = 1'($urandom_range(0, 1));
        cyc = 0; idx = 0; wbeat = 0; wcnt = 0; bcnt = 0;
        aw_done = 0; w_done = 0; done = 0; aborted = 0;
        while (!done && cyc < 300) begin
            @(negedge clk); cyc++;
            if (cyc == 2) chk("awvalid_latency", 32'(bus.awvalid), 1);
            if (abort_beat >= 0 && bus.wvalid && bus.wready && wbeat == abort_beat) begin
                chk("pre_reset_cresp_ready", 32'(bus.cresp.ready), 1);
                #2 reset = 1'b1;
                #1;
                chk("rst_async_wvalid", 32'(bus.wvalid), 0);
                chk("rst_async_awvalid", 32'(bus.awvalid), 0);
                chk("rst_async_wlast", 32'(bus.wlast), 0);
                chk("rst_async_cresp_ctl", {30'd0, bus.cresp.ready, bus.cresp.last}, 0);
                chk("rst_async_cresp_data", bus.cresp.data, 0);
                chk("rst_async_bus_err", 32'(bus.bus_err), 0);
                aq.delete(); wq.delete(); rq.delete();
                idle_inputs();
                @(posedge clk); @(posedge clk); #1;
                reset = 1'b0;
                aborted = 1;
                break;
            end
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.cresp.ready && !bus.cresp.last) idx++;
            if (bus.wvalid && bus.wready) begin
                if (wbeat == len) w_done = 1;
                wbeat++; wcnt = 0;
            end
            if (bus.bvalid && bus.bready) done = 1;
            @(posedge clk); #1;
            bus.awready = aw_done ? 1'b0 : 1'($urandom_range(0, 1));
            bus.creq.data = d[idx & 15]; bus.creq.strobe = s[idx & 15];
            if (aw_done && wbeat <= len) begin
                bus.wready = (wcnt >= stall); wcnt++;
            end else begin
                bus.wready = 1'b0;
            end
            if (done) begin
                bus.bvalid = 1'b0; bus.creq.valid = 1'b0;
            end else if (w_done) begin
                bus.bvalid = (bcnt >= bdelay); bcnt++;
                bus.bresp = bresp; bus.bid = 4'($urandom);
            end
        end
        if (!aborted) begin
            chk("write_done_in_budget", 32'(done), 1);
            @(negedge clk);
            chk("idle_after_write", {27'd0, bus.arvalid, bus.awvalid, bus.rready, bus.wvalid, bus.bready}, 0);
        end
        repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    // ---------------- main sequence ----------------
    int          r_len, r_size, r_last, r_err, r_stall, r_bdly;
    logic [31:0] r_addr;
    logic [1:0]  r_bresp;

    initial begin
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_arvalid", 32'(bus.arvalid), 0);
        chk("reset_awvalid", 32'(bus.awvalid), 0);
        chk("reset_wvalid", 32'(bus.wvalid), 0);
        chk("reset_ready_outs", {30'd0, bus.rready, bus.bready}, 0);
        chk("reset_bus_err", 32'(bus.bus_err), 0);
        chk("reset_cresp_ctl", {30'd0, bus.cresp.ready, bus.cresp.last}, 0);
        chk("reset_cresp_data", bus.cresp.data, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);

        run_read(32'h1fc0_0000, 0, 2, 0, 0, -1, 32'hdead_beef, 1'b1);
        run_read(32'h0000_1000, 7, 2, 7, 1, -1, 32'h0, 1'b1);
        run_write(32'h0000_2000, 3, 2, 3, 4, 2'b00, -1);
        run_write(32'h0000_3000, 1, 2, 0, 0, 2'b10, -1);
        run_read(32'h0000_4000, 3, 2, 2, 0, -1, 32'h100, 1'b1);
        run_write(32'h0000_5000, 3, 2, 1, 0, 2'b00, 1);
        run_read(32'h0000_6000, 3, 2, 3, 2, -1, 32'h0, 1'b0);
        run_write(32'h0000_7000, 0, 1, 0, 2, 2'b00, -1);

        for (int t = 0; t < 40; t++) begin
            r_len  = $urandom_range(0, 15);
            r_size = $urandom_range(0, 2);
            r_addr = $urandom & 32'hffff_fffc;
            if ($urandom_range(0, 1) == 1) begin
                r_stall = $urandom_range(0, 2);
                r_bdly  = $urandom_range(0, 3);
                r_bresp = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b00;
                run_write(r_addr, r_len, r_size, r_stall, r_bdly, r_bresp, -1);
            end else begin
                r_last = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : r_len;
                r_err  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, r_last) : -1;
                run_read(r_addr, r_len, r_size, r_last, 2, r_err, 32'h0, 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_addr_drained", aq.size(), 0);
        chk("scoreboard_wbeat_drained", wq.size(), 0);
        chk("scoreboard_resp_drained", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
